// File: rtl/limn2600_mem_arbiter_pkg.sv
// Shared types for the Limn2600 SRAM arbiter: FSM states, requester ids and
// the word-alignment rule applied to every incoming byte address.
// Latency: n/a (types only). Backpressure: n/a.
package limn2600_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_DM
  } req_id_t;

  localparam logic [31:0] ADDR_ALIGN_MASK = 32'h3;

  // Only whole 32-bit words are accessible; any low address bit set is an error.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr & ADDR_ALIGN_MASK) != 32'h0;
  endfunction

endpackage

// File: rtl/limn2600_mem_arbiter_rr_picker.sv
// 2-way round-robin picker: grants the single requester, or on a tie the one
// that did not win last time. Latency: combinational. Backpressure: none.
// Ports: req_i[0]=IF, req_i[1]=DM; last_i = previous winner;
//        grant_valid_o = any request; grant_id_o = chosen requester.
module limn2600_rr_picker
  import limn2600_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_i,
  output logic       grant_valid_o,
  output req_id_t    grant_id_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_id_o    = REQ_IF;
    if (req_i == 2'b11) begin
      grant_id_o = (last_i == REQ_IF) ? REQ_DM : REQ_IF;
    end else if (req_i[1]) begin
      grant_id_o = REQ_DM;
    end
  end

endmodule

// File: rtl/limn2600_mem_arbiter.sv
// Shares the single-ported Limn2600 SRAM between instruction fetch (IF, read
// only) and data (DM, read/write), round-robin, one SRAM access in flight.
// Latency: req sampled in IDLE cycle N -> mem_cs N+1 -> ack N+3 (misaligned: ack N+1).
// Backpressure: none queued; requesters hold req/addr/data until their ack.
// Ports: clk_i/rst_ni (async active-low); if_* and dm_* requester ports with
//        one-cycle ack/err/rdata; mem_* SRAM side; busy_o whenever not IDLE.
module limn2600_mem_arbiter
  import limn2600_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16   // >= 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // instruction fetch port
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  output logic                  if_ack_o,
  output logic                  if_err_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  // data port
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [31:0]           dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_ack_o,
  output logic                  dm_err_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  // SRAM side
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_in_o,
  input  logic [DATA_WIDTH-1:0] mem_data_out_i,
  input  logic                  mem_rdy_i,
  output logic                  busy_o
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  arb_state_t           state_q;
  req_id_t              last_q;
  req_id_t              owner_q;
  logic                 we_q;
  logic [TIMER_W-1:0]   timer_q;

  logic                  if_ack_q, if_err_q, dm_ack_q, dm_err_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, dm_rdata_q;
  logic                  mem_cs_q, mem_we_q, busy_q;
  logic [31:0]           mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_in_q;

  logic    grant_valid;
  req_id_t grant_id;

  // Request selected by the picker this cycle (only meaningful in IDLE).
  logic                  sel_we_d;
  logic [31:0]           sel_addr_d;
  logic [DATA_WIDTH-1:0] sel_wdata_d;

  // Response to be registered at the next edge, and to whom.
  logic                  resp_fire_d;
  logic                  resp_err_d;
  logic [DATA_WIDTH-1:0] resp_data_d;
  req_id_t               resp_id_d;

  limn2600_rr_picker u_picker (
    .req_i         ({dm_req_i, if_req_i}),
    .last_i        (last_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // IF is read-only, so its write enable and data are forced to zero.
  always_comb begin
    sel_we_d    = 1'b0;
    sel_addr_d  = if_addr_i;
    sel_wdata_d = '0;
    if (grant_id == REQ_DM) begin
      sel_we_d    = dm_we_i;
      sel_addr_d  = dm_addr_i;
      sel_wdata_d = dm_wdata_i;
    end
  end

  always_comb begin
    resp_fire_d = 1'b0;
    resp_err_d  = 1'b0;
    resp_data_d = '0;
    resp_id_d   = owner_q;
    case (state_q)
      ARB_IDLE: begin
        // Misaligned requests are answered without touching the SRAM.
        if (grant_valid && is_misaligned(sel_addr_d)) begin
          resp_fire_d = 1'b1;
          resp_err_d  = 1'b1;
          resp_id_d   = grant_id;
        end
      end
      ARB_WAIT: begin
        if (mem_rdy_i) begin
          resp_fire_d = 1'b1;
          resp_data_d = we_q ? '0 : mem_data_out_i;
        end else if (timer_q == TIMER_LAST) begin
          resp_fire_d = 1'b1;
          resp_err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ARB_IDLE;
      last_q        <= REQ_DM;    // IF wins the first tie after reset
      owner_q       <= REQ_IF;
      we_q          <= 1'b0;
      timer_q       <= '0;
      if_ack_q      <= 1'b0;
      if_err_q      <= 1'b0;
      if_rdata_q    <= '0;
      dm_ack_q      <= 1'b0;
      dm_err_q      <= 1'b0;
      dm_rdata_q    <= '0;
      mem_cs_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      // Ack/err/rdata are single-cycle and zero otherwise.
      if_ack_q   <= resp_fire_d && (resp_id_d == REQ_IF);
      if_err_q   <= resp_fire_d && (resp_id_d == REQ_IF) && resp_err_d;
      if_rdata_q <= (resp_fire_d && (resp_id_d == REQ_IF)) ? resp_data_d : '0;
      dm_ack_q   <= resp_fire_d && (resp_id_d == REQ_DM);
      dm_err_q   <= resp_fire_d && (resp_id_d == REQ_DM) && resp_err_d;
      dm_rdata_q <= (resp_fire_d && (resp_id_d == REQ_DM)) ? resp_data_d : '0;

      // SRAM bus is driven only during the ISSUE cycle.
      mem_cs_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;

      case (state_q)
        ARB_IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_id;
            last_q  <= grant_id;
            we_q    <= sel_we_d;
            busy_q  <= 1'b1;
            if (resp_fire_d) begin
              state_q <= ARB_RESP;
            end else begin
              state_q       <= ARB_ISSUE;
              mem_cs_q      <= 1'b1;
              mem_we_q      <= sel_we_d;
              mem_addr_q    <= sel_addr_d;
              mem_data_in_q <= sel_wdata_d;
            end
          end
        end
        ARB_ISSUE: begin
          timer_q <= '0;
          state_q <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (resp_fire_d) begin
            state_q <= ARB_RESP;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack_o      = if_ack_q;
  assign if_err_o      = if_err_q;
  assign if_rdata_o    = if_rdata_q;
  assign dm_ack_o      = dm_ack_q;
  assign dm_err_o      = dm_err_q;
  assign dm_rdata_o    = dm_rdata_q;
  assign mem_cs_o      = mem_cs_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_in_o = mem_data_in_q;
  assign busy_o        = busy_q;

endmodule
